// File: rtl/cpu16_pkg.sv
// Shared types and encodings for the cpu16 sequencer and its decoder.
// Holds FSM states, opcode/function encodings, error codes and ALU select bundle.
package cpu16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_HI,
    ST_FETCH_LO,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALTED
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [3:0] FN_ADD = 4'b1010;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b1100;
  localparam logic [3:0] FN_OR  = 4'b1110;
  localparam logic [3:0] FN_XOR = 4'b1101;
  localparam logic [3:0] FN_NOT = 4'b1011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic sel_imm;
    logic s_sub;
    logic s_fas;
    logic s_and;
    logic s_or;
    logic s_xor;
    logic s_not;
  } alu_sel_t;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/cpu16_ctrl_decode.sv
// Combinational instruction decode: IR -> legal/halt flags, ALU selects, immediate.
// Zero latency; no handshake, the sequencer decides when the selects are used.
module cpu16_ctrl_decode
  import cpu16_pkg::*;
(
  input  logic [15:0] ir,
  output logic        legal,
  output logic        is_hlt,
  output alu_sel_t    sel,
  output logic [15:0] imm
);

  always_comb begin
    legal  = 1'b0;
    is_hlt = 1'b0;
    sel    = '0;
    imm    = sext8(ir[7:0]);
    case (ir[15:12])
      OP_ALU: begin
        legal = 1'b1;
        case (ir[7:4])
          FN_ADD: sel.s_fas = 1'b1;
          FN_SUB: begin
            sel.s_fas = 1'b1;
            sel.s_sub = 1'b1;
          end
          FN_AND: sel.s_and = 1'b1;
          FN_OR:  sel.s_or  = 1'b1;
          FN_XOR: sel.s_xor = 1'b1;
          FN_NOT: sel.s_not = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        legal       = 1'b1;
        sel.s_fas   = 1'b1;
        sel.sel_imm = 1'b1;
      end
      OP_HLT:  is_hlt = 1'b1;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu16_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit CPU.
// 5 cycles per instruction at zero-wait ACK; fetch stalls on MEM_ACK with a bus timeout.
module cpu16_seq_ctrl
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        CK,
  input  logic        RST_N,
  input  logic        RUN,
  output logic        MEM_REQ,
  output logic [15:0] MEM_ADDR,
  input  logic [7:0]  MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic        REG_WE,
  output logic [3:0]  REG_WN,
  output logic [3:0]  REG_N1,
  output logic [3:0]  REG_N2,
  output logic        SEL_IMM,
  output logic [15:0] IMM,
  output logic        S_SUB,
  output logic        S_FAS,
  output logic        S_AND,
  output logic        S_OR,
  output logic        S_XOR,
  output logic        S_NOT,
  output logic        RETIRE,
  output logic        HALT,
  output logic [1:0]  ERR
);

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  tmo_inc;

  logic        dec_legal;
  logic        dec_hlt;
  alu_sel_t    dec_sel;
  logic [15:0] dec_imm;
  logic        sel_act;

  cpu16_ctrl_decode u_decode (
    .ir     (ir_q),
    .legal  (dec_legal),
    .is_hlt (dec_hlt),
    .sel    (dec_sel),
    .imm    (dec_imm)
  );

  assign tmo_inc = tmo_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (RUN) begin
          state_d = ST_FETCH_HI;
          tmo_d   = 8'd0;
        end
      end
      ST_FETCH_HI: begin
        if (MEM_ACK) begin
          ir_d[15:8] = MEM_RDATA;
          state_d    = ST_FETCH_LO;
          tmo_d      = 8'd0;
        end else if (tmo_inc == TMO_LIM) begin
          state_d = ST_HALTED;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_FETCH_LO: begin
        if (MEM_ACK) begin
          ir_d[7:0] = MEM_RDATA;
          state_d   = ST_DECODE;
          tmo_d     = 8'd0;
        end else if (tmo_inc == TMO_LIM) begin
          state_d = ST_HALTED;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          // HLT and illegal both stop here without advancing PC
          state_d = ST_HALTED;
          err_d   = dec_hlt ? ERR_NONE : ERR_ILLEGAL;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        pc_d    = pc_q + 16'd2;
        tmo_d   = 8'd0;
        state_d = RUN ? ST_FETCH_HI : ST_IDLE;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      tmo_q   <= 8'd0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs come straight from registered state so they hold until ACK
  assign MEM_REQ  = (state_q == ST_FETCH_HI) || (state_q == ST_FETCH_LO);
  assign MEM_ADDR = (state_q == ST_FETCH_HI) ? pc_q :
                    (state_q == ST_FETCH_LO) ? (pc_q + 16'd1) : 16'h0000;

  assign sel_act = (state_q == ST_EXEC) || (state_q == ST_WB);
  assign SEL_IMM = sel_act & dec_sel.sel_imm;
  assign S_SUB   = sel_act & dec_sel.s_sub;
  assign S_FAS   = sel_act & dec_sel.s_fas;
  assign S_AND   = sel_act & dec_sel.s_and;
  assign S_OR    = sel_act & dec_sel.s_or;
  assign S_XOR   = sel_act & dec_sel.s_xor;
  assign S_NOT   = sel_act & dec_sel.s_not;

  assign PC     = pc_q;
  assign IR     = ir_q;
  assign IMM    = dec_imm;
  assign REG_WN = ir_q[11:8];
  assign REG_N1 = ir_q[11:8];
  assign REG_N2 = ir_q[3:0];
  assign REG_WE = (state_q == ST_WB);
  assign RETIRE = (state_q == ST_WB);
  assign HALT   = (state_q == ST_HALTED);
  assign ERR    = err_q;

endmodule

// File: tb/tb_cpu16_seq_ctrl.sv
// Directed bench for cpu16_seq_ctrl with a byte memory responder and a retire scoreboard.
module tb_cpu16_seq_ctrl;

  logic        CK = 1'b0;
  logic        RST_N, RUN;
  logic        MEM_REQ, MEM_ACK;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_RDATA;
  logic [15:0] PC, IR, IMM;
  logic        REG_WE, SEL_IMM, RETIRE, HALT;
  logic [3:0]  REG_WN, REG_N1, REG_N2;
  logic        S_SUB, S_FAS, S_AND, S_OR, S_XOR, S_NOT;
  logic [1:0]  ERR;

  logic        run2;
  logic        w_req, w_ack, w_we, w_selimm, w_ret, w_halt;
  logic [15:0] w_addr, w_pc, w_ir, w_imm;
  logic [7:0]  w_rdata;
  logic [3:0]  w_wn, w_n1, w_n2;
  logic        w_sub, w_fas, w_and, w_or, w_xor, w_not;
  logic [1:0]  w_err;

  logic [7:0]  mem [0:65535];
  int          wait_cnt = 0;
  int          ack_dly = 0;
  logic        ack_en = 1'b1;
  logic        force_ack = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [6:0]  sel_obs;

  typedef struct {
    logic [3:0]  wn;
    logic [3:0]  n2;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [6:0]  sel;
  } exp_t;
  exp_t sb_q[$];

  always #5 CK = ~CK;

  cpu16_seq_ctrl u_dut (
    .CK(CK), .RST_N(RST_N), .RUN(RUN), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .PC(PC), .IR(IR), .REG_WE(REG_WE),
    .REG_WN(REG_WN), .REG_N1(REG_N1), .REG_N2(REG_N2), .SEL_IMM(SEL_IMM), .IMM(IMM),
    .S_SUB(S_SUB), .S_FAS(S_FAS), .S_AND(S_AND), .S_OR(S_OR), .S_XOR(S_XOR),
    .S_NOT(S_NOT), .RETIRE(RETIRE), .HALT(HALT), .ERR(ERR)
  );

  cpu16_seq_ctrl #(.RESET_PC(16'hFFFE), .TIMEOUT(15)) u_dut_w (
    .CK(CK), .RST_N(RST_N), .RUN(run2), .MEM_REQ(w_req), .MEM_ADDR(w_addr),
    .MEM_RDATA(w_rdata), .MEM_ACK(w_ack), .PC(w_pc), .IR(w_ir), .REG_WE(w_we),
    .REG_WN(w_wn), .REG_N1(w_n1), .REG_N2(w_n2), .SEL_IMM(w_selimm), .IMM(w_imm),
    .S_SUB(w_sub), .S_FAS(w_fas), .S_AND(w_and), .S_OR(w_or), .S_XOR(w_xor),
    .S_NOT(w_not), .RETIRE(w_ret), .HALT(w_halt), .ERR(w_err)
  );

  // Responder: ACK after ack_dly wait cycles of continuous REQ
  always @(posedge CK) begin
    if (MEM_REQ && !MEM_ACK) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end
  assign MEM_ACK   = force_ack | (ack_en & MEM_REQ & (wait_cnt >= ack_dly));
  assign MEM_RDATA = mem[MEM_ADDR];
  assign w_ack     = w_req;
  assign w_rdata   = mem[w_addr];
  assign sel_obs   = {SEL_IMM, S_SUB, S_FAS, S_AND, S_OR, S_XOR, S_NOT};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [3:0] wn, input logic [3:0] n2,
                                  input logic [15:0] imm, input logic [15:0] pc,
                                  input logic [6:0] sel);
    exp_t e;
    e.wn = wn; e.n2 = n2; e.imm = imm; e.pc = pc; e.sel = sel;
    return e;
  endfunction

  task automatic sb_check(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty queue expected an entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_we"},  REG_WE, 1);
      chk({tag, "_ret"}, RETIRE, 1);
      chk({tag, "_wn"},  REG_WN, e.wn);
      chk({tag, "_n1"},  REG_N1, e.wn);
      chk({tag, "_n2"},  REG_N2, e.n2);
      chk({tag, "_imm"}, IMM, e.imm);
      chk({tag, "_sel"}, sel_obs, e.sel);
      chk({tag, "_pc"},  PC, e.pc);
    end
  endtask

  task automatic wait_retire(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (RETIRE !== 1'b1 && cyc < budget) begin
      @(negedge CK);
      cyc++;
    end
    chk({tag, "_retire_seen"}, RETIRE, 1);
  endtask

  task automatic wait_halt(input int budget, output int cyc, output int we_n, output int ret_n);
    cyc = 0; we_n = 0; ret_n = 0;
    while (HALT !== 1'b1 && cyc < budget) begin
      @(negedge CK);
      cyc++;
      if (REG_WE === 1'b1) we_n++;
      if (RETIRE === 1'b1) ret_n++;
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0; RUN = 1'b0; run2 = 1'b0;
    ack_en = 1'b1; ack_dly = 0; force_ack = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge CK);
    RST_N = 1'b1;
    @(negedge CK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, we_n, ret_n;
    mem[0] = 8'h0E; mem[1] = 8'hCB; mem[2] = 8'h43; mem[3] = 8'hFF;
    mem[4] = 8'h05; mem[5] = 8'h24; mem[6] = 8'hF0; mem[7] = 8'h00;
    mem[16'hFFFE] = 8'h0E; mem[16'hFFFF] = 8'hCB;

    // Reset state, then AND r14,r11 followed by ADDI, SUB and HLT
    do_reset();
    chk("rst_pc", PC, 16'h0000);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_req", MEM_REQ, 0);
    chk("rst_halt", HALT, 0);
    chk("rst_err", ERR, 0);
    chk("rst_we", REG_WE, 0);
    chk("rst_sel", sel_obs, 0);
    chk("rst_imm", IMM, 16'h0000);
    sb_q.push_back(mk_exp(4'hE, 4'hB, 16'hFFCB, 16'h0000, 7'b0001000));
    RUN = 1'b1;
    @(negedge CK);
    chk("c1_req", MEM_REQ, 1);
    chk("c1_addr", MEM_ADDR, 16'h0000);
    chk("c1_ir", IR, 16'h0000);
    @(negedge CK);
    chk("c2_addr", MEM_ADDR, 16'h0001);
    chk("c2_ir", IR, 16'h0E00);
    @(negedge CK);
    chk("c3_ir", IR, 16'h0ECB);
    chk("c3_req", MEM_REQ, 0);
    chk("c3_and", S_AND, 0);
    @(negedge CK);
    chk("c4_and", S_AND, 1);
    chk("c4_we", REG_WE, 0);
    @(negedge CK);
    sb_check("add");
    @(negedge CK);
    chk("c6_pc", PC, 16'h0002);
    chk("c6_we", REG_WE, 0);
    chk("c6_addr", MEM_ADDR, 16'h0002);
    sb_q.push_back(mk_exp(4'h3, 4'hF, 16'hFFFF, 16'h0002, 7'b1010000));
    sb_q.push_back(mk_exp(4'h5, 4'h4, 16'h0024, 16'h0004, 7'b0110000));
    wait_retire("addi", 10, cyc);
    chk("addi_lat", cyc, 4);
    sb_check("addi");
    @(negedge CK);
    wait_retire("sub", 10, cyc);
    sb_check("sub");
    @(negedge CK);
    wait_halt(10, cyc, we_n, ret_n);
    chk("hlt_halt", HALT, 1);
    chk("hlt_err", ERR, 2'b00);
    chk("hlt_pc", PC, 16'h0006);
    chk("hlt_we", we_n, 0);
    chk("hlt_ret", ret_n, 0);
    repeat (3) @(negedge CK);
    chk("hlt_sticky", HALT, 1);
    chk("hlt_noreq", MEM_REQ, 0);

    // Three wait cycles per byte; RUN drops during EXEC
    do_reset();
    ack_dly = 3;
    sb_q.push_back(mk_exp(4'hE, 4'hB, 16'hFFCB, 16'h0000, 7'b0001000));
    RUN = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge CK);
      if (c <= 8) begin
        chk($sformatf("dly_c%0d_req", c), MEM_REQ, 1);
        chk($sformatf("dly_c%0d_addr", c), MEM_ADDR, (c <= 4) ? 16'h0000 : 16'h0001);
        chk($sformatf("dly_c%0d_ir", c), IR, (c <= 4) ? 16'h0000 : 16'h0E00);
      end
      if (c < 11) chk($sformatf("dly_c%0d_ret", c), RETIRE, 0);
      if (c == 10) begin
        chk("dly_exec_and", S_AND, 1);
        RUN = 1'b0;
      end
      if (c == 11) sb_check("dly");
    end
    for (int c = 12; c <= 15; c++) begin
      @(negedge CK);
      chk($sformatf("idle_c%0d_req", c), MEM_REQ, 0);
      chk($sformatf("idle_c%0d_pc", c), PC, 16'h0002);
    end
    force_ack = 1'b1;
    repeat (2) @(negedge CK);
    chk("stray_ack_ir", IR, 16'h0ECB);
    chk("stray_ack_req", MEM_REQ, 0);
    force_ack = 1'b0;

    // No ACK at all: bus timeout after 15 cycles in FETCH_HI
    do_reset();
    ack_en = 1'b0;
    RUN = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CK);
      chk($sformatf("tmo_c%0d_req", c), MEM_REQ, 1);
      chk($sformatf("tmo_c%0d_halt", c), HALT, 0);
    end
    @(negedge CK);
    chk("tmo_halt", HALT, 1);
    chk("tmo_err", ERR, 2'b10);
    chk("tmo_req", MEM_REQ, 0);
    chk("tmo_pc", PC, 16'h0000);

    // Illegal ALU function
    mem[0] = 8'h00; mem[1] = 8'h00;
    do_reset();
    RUN = 1'b1;
    wait_halt(20, cyc, we_n, ret_n);
    chk("ill_halt", HALT, 1);
    chk("ill_err", ERR, 2'b01);
    chk("ill_pc", PC, 16'h0000);
    chk("ill_we", we_n, 0);
    chk("ill_ret", ret_n, 0);
    mem[0] = 8'h0E; mem[1] = 8'hCB;

    // Asynchronous reset while waiting in FETCH_LO
    do_reset();
    ack_dly = 3;
    RUN = 1'b1;
    repeat (6) @(negedge CK);
    chk("arst_pre_addr", MEM_ADDR, 16'h0001);
    chk("arst_pre_req", MEM_REQ, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_req", MEM_REQ, 0);
    chk("arst_pc", PC, 16'h0000);
    chk("arst_ir", IR, 16'h0000);
    RUN = 1'b0;
    @(negedge CK);
    RST_N = 1'b1;
    ack_dly = 0;
    @(negedge CK);

    // PC wrap from RESET_PC=0xFFFE on the second instance
    chk("wrap_rst_pc", w_pc, 16'hFFFE);
    run2 = 1'b1;
    @(negedge CK);
    chk("wrap_c1_addr", w_addr, 16'hFFFE);
    @(negedge CK);
    chk("wrap_c2_addr", w_addr, 16'hFFFF);
    @(negedge CK);
    chk("wrap_c3_ir", w_ir, 16'h0ECB);
    @(negedge CK);
    run2 = 1'b0;
    @(negedge CK);
    chk("wrap_c5_ret", w_ret, 1);
    chk("wrap_c5_pc", w_pc, 16'hFFFE);
    @(negedge CK);
    chk("wrap_c6_pc", w_pc, 16'h0000);
    chk("wrap_c6_req", w_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
